// File: rtl/axi_ifetch_queue.sv
// Instruction fetch front end: AXI4 line bursts unpacked into a
// {pc, instr} queue for decode, with redirect flush and zero-halt.
module axi_ifetch_queue #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int INSTR_W    = 32,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  entry,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  m_axi_araddr,
  output logic               m_axi_arvalid,
  input  logic               m_axi_arready,
  output logic [7:0]         m_axi_arlen,
  output logic [2:0]         m_axi_arsize,
  output logic [1:0]         m_axi_arburst,
  input  logic [DATA_W-1:0]  m_axi_rdata,
  input  logic               m_axi_rvalid,
  output logic               m_axi_rready,
  input  logic               m_axi_rlast,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               halted
);

  localparam int WPB     = DATA_W / INSTR_W;
  localparam int WPL     = BURST_LEN * WPB;
  localparam int BEAT_B  = DATA_W / 8;
  localparam int INSTR_B = INSTR_W / 8;
  localparam int LB      = BURST_LEN * BEAT_B;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LB - 1);
  localparam logic [CNT_W-1:0]  FREE_MAX  = CNT_W'(FIFO_DEPTH - WPL);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [7:0]          beat_q, beat_d;
  logic                halted_q, halted_d;
  logic                kill_q, kill_d;
  logic [PTR_W-1:0]    wr_q, wr_d;
  logic [PTR_W-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   pc_mem_q  [FIFO_DEPTH];
  logic [ADDR_W-1:0]   pc_mem_d  [FIFO_DEPTH];
  logic [INSTR_W-1:0]  ins_mem_q [FIFO_DEPTH];
  logic [INSTR_W-1:0]  ins_mem_d [FIFO_DEPTH];

  logic                redir;
  logic                beat_ok;
  logic                pop;
  logic                stop;
  logic [CNT_W-1:0]    npush;
  logic [PTR_W-1:0]    widx;
  logic [ADDR_W-1:0]   off;
  logic [ADDR_W-1:0]   fetch_off;
  logic [INSTR_W-1:0]  wrd;

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'($clog2(BEAT_B));
  assign m_axi_arburst = 2'b01;
  assign m_axi_rready  = rready_q;
  assign if_valid      = (cnt_q != '0);
  assign if_instr      = ins_mem_q[rd_q];
  assign if_pc         = pc_mem_q[rd_q];
  assign halted        = halted_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    beat_d     = beat_q;
    halted_d   = halted_q;
    kill_d     = kill_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    pc_mem_d   = pc_mem_q;
    ins_mem_d  = ins_mem_q;
    stop       = 1'b0;
    npush      = '0;
    widx       = wr_q;
    off        = '0;
    wrd        = '0;
    fetch_off  = fetch_pc_q & ~LINE_MASK;

    redir   = redirect_valid && (state_q != S_HALT) && !halted_q;
    beat_ok = rready_q && m_axi_rvalid;
    pop     = if_valid && if_ready && !redir;

    // Words below the fetch PC are skipped; a zero word ends the stream.
    if (state_q == S_DATA && beat_ok && !redir && !halted_q) begin
      for (int k = 0; k < WPB; k++) begin
        off = ADDR_W'(beat_q) * ADDR_W'(BEAT_B) + ADDR_W'(k * INSTR_B);
        wrd = m_axi_rdata[k*INSTR_W +: INSTR_W];
        if (!stop && off >= fetch_off) begin
          if (wrd == '0) begin
            stop     = 1'b1;
            halted_d = 1'b1;
          end else begin
            widx = wr_q + npush[PTR_W-1:0];
            pc_mem_d[widx]  = araddr_q + off;
            ins_mem_d[widx] = wrd;
            npush = npush + CNT_W'(1);
          end
        end
      end
    end

    if (redir) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = wr_q + npush[PTR_W-1:0];
      rd_d  = rd_q + PTR_W'(pop);
      cnt_d = cnt_q + npush - CNT_W'(pop);
    end

    unique case (state_q)
      S_IDLE: begin
        if (!redir && !halted_q && cnt_q <= FREE_MAX) begin
          state_d   = S_ADDR;
          arvalid_d = 1'b1;
          araddr_d  = fetch_pc_q & LINE_MASK;
          kill_d    = 1'b0;
        end
      end
      S_ADDR: begin
        if (redir) kill_d = 1'b1;
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          beat_d    = '0;
          kill_d    = 1'b0;
          state_d   = (kill_q || redir) ? S_DRAIN : S_DATA;
        end
      end
      S_DATA: begin
        if (beat_ok) begin
          beat_d = beat_q + 8'd1;
          if (m_axi_rlast) begin
            rready_d = 1'b0;
            if (redir) begin
              state_d = S_IDLE;
            end else if (halted_d) begin
              state_d = S_HALT;
            end else begin
              state_d    = S_IDLE;
              fetch_pc_d = araddr_q + ADDR_W'(LB);
            end
          end else if (redir) begin
            state_d = S_DRAIN;
          end
        end else if (redir) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (beat_ok && m_axi_rlast) begin
          rready_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_HALT: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (redir) fetch_pc_d = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= entry;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      beat_q     <= '0;
      halted_q   <= 1'b0;
      kill_q     <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      beat_q     <= beat_d;
      halted_q   <= halted_d;
      kill_q     <= kill_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q  <= pc_mem_d;
    ins_mem_q <= ins_mem_d;
  end

endmodule

// File: tb/tb_axi_ifetch_queue.sv
// Bench for axi_ifetch_queue: AXI slave model, decode consumer and an
// expected-stream model (pc = start + 4*i, instr = memory word at pc).
module tb_axi_ifetch_queue;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 32;
  localparam int BL = 8;
  localparam int FD = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] entry = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] m_axi_araddr;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic [DW-1:0] m_axi_rdata;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic          m_axi_rlast;
  logic          if_valid;
  logic          if_ready;
  logic [IW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          halted;

  axi_ifetch_queue #(
    .ADDR_W(AW), .DATA_W(DW), .INSTR_W(IW),
    .BURST_LEN(BL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .entry(entry),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .m_axi_rlast(m_axi_rlast),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int ar_pct  = 100;
  int r_pct   = 100;
  int rdy_pct = 100;
  bit ar_hold  = 1'b0;
  bit rdy_hold = 1'b0;

  bit          zero_en = 1'b0;
  logic [AW-1:0] zero_addr = '0;

  logic [AW-1:0] pend[$];
  int            beat = 0;
  logic [AW-1:0] ar_log[$];
  logic [7:0]    arlen_log[$];
  logic [2:0]    arsize_log[$];
  logic [1:0]    arburst_log[$];
  int            pops_at_ar[$];
  int            pend_at_ar[$];
  logic [AW-1:0] got_pc[$];
  logic [IW-1:0] got_ins[$];
  int            total_pops = 0;
  bit            ar_wait = 1'b0;
  logic [AW-1:0] ar_wait_addr = '0;

  function automatic logic [IW-1:0] word_at(input logic [AW-1:0] a);
    if (zero_en && a == zero_addr) return '0;
    return {a[31:2], 2'b11};
  endfunction

  task automatic check64(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Slave, consumer and monitor: observe at negedge, drive after posedge.
  initial begin : env
    bit ar_fire, r_fire, pop, rst_s;
    logic [AW-1:0] a;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rlast   = 1'b0;
    if_ready      = 1'b0;
    forever begin
      @(negedge clk);
      rst_s   = reset;
      ar_fire = m_axi_arvalid && m_axi_arready;
      r_fire  = m_axi_rvalid && m_axi_rready;
      pop     = if_valid && if_ready && !redirect_valid;
      if (ar_wait) begin
        check64("ar_hold_valid", 64'(m_axi_arvalid), 64'd1);
        check64("ar_hold_addr", m_axi_araddr, ar_wait_addr);
      end
      ar_wait      = !rst_s && m_axi_arvalid && !m_axi_arready;
      ar_wait_addr = m_axi_araddr;
      if (!rst_s) begin
        if (r_fire && pend.size() != 0) begin
          beat++;
          if (beat == BL) begin
            void'(pend.pop_front());
            beat = 0;
          end
        end
        if (ar_fire) begin
          ar_log.push_back(m_axi_araddr);
          arlen_log.push_back(m_axi_arlen);
          arsize_log.push_back(m_axi_arsize);
          arburst_log.push_back(m_axi_arburst);
          pops_at_ar.push_back(total_pops);
          pend_at_ar.push_back(pend.size());
          pend.push_back(m_axi_araddr);
        end
        if (pop) begin
          got_pc.push_back(if_pc);
          got_ins.push_back(if_instr);
          total_pops++;
        end
      end
      @(posedge clk);
      #1;
      if (rst_s) begin
        pend.delete();
        beat = 0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
      end else begin
        m_axi_arready = !ar_hold && ($urandom_range(99) < ar_pct);
        if (!m_axi_rvalid || r_fire) begin
          if (pend.size() != 0 && $urandom_range(99) < r_pct) begin
            a = pend[0] + AW'(beat * (DW / 8));
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = {word_at(a + AW'(4)), word_at(a)};
            m_axi_rlast  = (beat == BL - 1);
          end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
          end
        end
      end
      if_ready = !rdy_hold && ($urandom_range(99) < rdy_pct);
    end
  end

  task automatic clear_logs();
    got_pc.delete();
    got_ins.delete();
    ar_log.delete();
    arlen_log.delete();
    arsize_log.delete();
    arburst_log.delete();
    pops_at_ar.delete();
    pend_at_ar.delete();
    total_pops = 0;
  endtask

  task automatic do_reset(input logic [AW-1:0] e);
    entry = e;
    redirect_valid = 1'b0;
    reset = 1'b1;
    tick(3);
    check64("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check64("rst_rready", 64'(m_axi_rready), 64'd0);
    check64("rst_if_valid", 64'(if_valid), 64'd0);
    check64("rst_halted", 64'(halted), 64'd0);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic redirect_to(input logic [AW-1:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  // Delivered words must be the in-order stream from start.
  task automatic check_stream(input string tag, input logic [AW-1:0] start,
                              input int min_n);
    logic [AW-1:0] pc;
    check64({tag, "_count"}, 64'(got_pc.size() >= min_n), 64'd1);
    foreach (got_pc[i]) begin
      pc = start + AW'(4 * i);
      check64({tag, "_pc"}, got_pc[i], pc);
      check64({tag, "_instr"}, 64'(got_ins[i]), 64'(word_at(pc)));
    end
    got_pc.delete();
    got_ins.delete();
  endtask

  task automatic wait_ar(input string tag, input int n);
    int t = 0;
    while (ar_log.size() < n && t < 3000) begin
      tick(1);
      t++;
    end
    check64(tag, 64'(ar_log.size() >= n), 64'd1);
  endtask

  task automatic wait_pops(input string tag, input int n);
    int t = 0;
    while (got_pc.size() < n && t < 3000) begin
      tick(1);
      t++;
    end
    check64(tag, 64'(got_pc.size() >= n), 64'd1);
  endtask

  initial begin : main
    int t;
    int low_cnt;
    logic [AW-1:0] a0;
    logic [AW-1:0] start;
    logic [AW-1:0] rpc;

    // Sequential fetch
    do_reset(64'h8000_0000);
    wait_pops("seq_pops", 16);
    check64("seq_araddr", ar_log[0], 64'h8000_0000);
    check64("seq_arlen", 64'(arlen_log[0]), 64'd7);
    check64("seq_arsize", 64'(arsize_log[0]), 64'd3);
    check64("seq_arburst", 64'(arburst_log[0]), 64'd1);
    wait_ar("seq_ar2", 2);
    check64("seq_araddr2", ar_log[1], 64'h8000_0040);
    check_stream("seq", 64'h8000_0000, 16);

    // Unaligned entry
    do_reset(64'h8000_0008);
    wait_pops("una_pops", 20);
    check64("una_araddr", ar_log[0], 64'h8000_0000);
    check64("una_first_pc", got_pc[0], 64'h8000_0008);
    low_cnt = 0;
    foreach (got_pc[i]) if (got_pc[i] < 64'h8000_0040) low_cnt++;
    check64("una_line0_words", 64'(low_cnt), 64'd14);
    check_stream("una", 64'h8000_0008, 20);

    // Backpressure
    rdy_hold = 1'b1;
    do_reset(64'h8000_0000);
    tick(20);
    check64("bp_if_valid_mid", 64'(if_valid), 64'd1);
    tick(20);
    check64("bp_one_ar", 64'(ar_log.size()), 64'd1);
    check64("bp_if_valid", 64'(if_valid), 64'd1);
    check64("bp_no_pops", 64'(got_pc.size()), 64'd0);
    rdy_hold = 1'b0;
    rdy_pct = 50;
    wait_ar("bp_ar2", 2);
    check64("bp_pops_before_ar2", 64'(pops_at_ar[1] >= 16), 64'd1);
    wait_pops("bp_pops", 32);
    check_stream("bp", 64'h8000_0000, 32);
    rdy_pct = 100;

    // Redirect mid-burst at beat 3
    r_pct = 60;
    do_reset(64'h8000_0000);
    t = 0;
    while (!(ar_log.size() == 1 && beat == 3) && t < 3000) begin
      tick(1);
      t++;
    end
    check64("rd_beat3_seen", 64'(beat), 64'd3);
    redirect_to(64'h8000_1004);
    check64("rd_flush", 64'(if_valid), 64'd0);
    check_stream("rd_old", 64'h8000_0000, 0);
    wait_ar("rd_ar2", 2);
    check64("rd_araddr2", ar_log[1], 64'h8000_1000);
    check64("rd_drained", 64'(pend_at_ar[1]), 64'd0);
    wait_pops("rd_pops", 8);
    check_stream("rd_new", 64'h8000_1004, 8);
    r_pct = 100;

    // Redirect while AR stalled
    ar_hold = 1'b1;
    do_reset(64'h8000_0000);
    t = 0;
    while (!m_axi_arvalid && t < 100) begin
      tick(1);
      t++;
    end
    check64("ars_arvalid", 64'(m_axi_arvalid), 64'd1);
    a0 = m_axi_araddr;
    redirect_to(64'h8000_2010);
    tick(5);
    check64("ars_still_valid", 64'(m_axi_arvalid), 64'd1);
    check64("ars_addr_stable", m_axi_araddr, a0);
    check64("ars_no_ar", 64'(ar_log.size()), 64'd0);
    check64("ars_empty", 64'(if_valid), 64'd0);
    ar_hold = 1'b0;
    ar_pct = 60;
    wait_ar("ars_ar2", 2);
    check64("ars_old_addr", ar_log[0], 64'h8000_0000);
    check64("ars_new_addr", ar_log[1], 64'h8000_2000);
    check64("ars_drained", 64'(pend_at_ar[1]), 64'd0);
    wait_pops("ars_pops", 6);
    check_stream("ars", 64'h8000_2010, 6);
    ar_pct = 100;

    // Halt on zero word 5
    zero_en = 1'b1;
    zero_addr = 64'h8000_0014;
    r_pct = 70;
    do_reset(64'h8000_0000);
    t = 0;
    while (!halted && t < 3000) begin
      tick(1);
      t++;
    end
    check64("halt_seen", 64'(halted), 64'd1);
    tick(40);
    check64("halt_sticky", 64'(halted), 64'd1);
    check64("halt_one_ar", 64'(ar_log.size()), 64'd1);
    check64("halt_arvalid", 64'(m_axi_arvalid), 64'd0);
    check64("halt_beats_consumed", 64'(pend.size()), 64'd0);
    check64("halt_words", 64'(got_pc.size()), 64'd5);
    check_stream("halt", 64'h8000_0000, 5);
    zero_en = 1'b0;
    do_reset(64'h8000_0000);
    wait_pops("halt_refetch_pops", 4);
    check64("halt_cleared", 64'(halted), 64'd0);
    check_stream("halt_refetch", 64'h8000_0000, 4);
    r_pct = 100;

    // Wrap at the top of memory
    do_reset(64'hFFFF_FFFF_FFFF_FFF0);
    wait_pops("wrap_pops", 10);
    check64("wrap_ar0", ar_log[0], 64'hFFFF_FFFF_FFFF_FFC0);
    wait_ar("wrap_ar2", 2);
    check64("wrap_ar1", ar_log[1], 64'h0);
    check_stream("wrap", 64'hFFFF_FFFF_FFFF_FFF0, 10);

    // Randomized redirects and resets
    start = 64'h8000_0000 + AW'(4 * $urandom_range(0, 4095));
    do_reset(start);
    for (int it = 0; it < 24; it++) begin
      ar_pct  = $urandom_range(30, 100);
      r_pct   = $urandom_range(30, 100);
      rdy_pct = $urandom_range(10, 100);
      tick($urandom_range(1, 120));
      rpc = 64'h8000_0000 + AW'(4 * $urandom_range(0, 4095));
      if ($urandom_range(9) == 0) begin
        check_stream("rnd_pre_reset", start, 0);
        do_reset(rpc);
      end else begin
        redirect_to(rpc);
        check_stream("rnd", start, 0);
      end
      start = rpc;
    end
    ar_pct = 100;
    r_pct = 100;
    rdy_pct = 100;
    tick(200);
    check_stream("rnd_final", start, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
